// File: rtl/n101_mrom_arb.sv
// Two-port arbiter in front of a combinational mask ROM: one command in flight, registered response.
// Define N101_MROM_ARB_RR_EN for round-robin arbitration; otherwise IFU has fixed priority.
module n101_mrom_arb #(
  parameter int AW = 12,
  parameter int DW = 32,
  parameter int DP = 1024
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          ifu_cmd_valid,
  output logic          ifu_cmd_ready,
  input  logic [AW-1:0] ifu_cmd_addr,
  input  logic          ifu_cmd_read,
  output logic          ifu_rsp_valid,
  input  logic          ifu_rsp_ready,
  output logic [DW-1:0] ifu_rsp_rdata,
  output logic          ifu_rsp_err,
  input  logic          sys_cmd_valid,
  output logic          sys_cmd_ready,
  input  logic [AW-1:0] sys_cmd_addr,
  input  logic          sys_cmd_read,
  output logic          sys_rsp_valid,
  input  logic          sys_rsp_ready,
  output logic [DW-1:0] sys_rsp_rdata,
  output logic          sys_rsp_err,
  output logic [AW-3:0] rom_addr,
  input  logic [DW-1:0] rom_dout
);

  typedef enum logic [1:0] {IDLE, RSP_IFU, RSP_SYS} state_e;

  state_e        state_q;
  logic          ifu_rsp_valid_q, sys_rsp_valid_q;
  logic [DW-1:0] ifu_rsp_rdata_q, sys_rsp_rdata_q;
  logic          ifu_rsp_err_q, sys_rsp_err_q;

  logic          free;
  logic          any_valid;
  logic          ifu_pick;
  logic          accept;
  logic [AW-1:0] sel_addr;
  logic          sel_read;
  logic          cmd_err;
  logic [DW-1:0] rdata_d;

`ifdef N101_MROM_ARB_RR_EN
  logic          last_grant_q; // 1 = SYS was granted last
  assign ifu_pick = ifu_cmd_valid & (~sys_cmd_valid | last_grant_q);
`else
  assign ifu_pick = ifu_cmd_valid;
`endif

  assign any_valid = ifu_cmd_valid | sys_cmd_valid;
  assign free      = (state_q == IDLE)
                   | ((state_q == RSP_IFU) & ifu_rsp_ready)
                   | ((state_q == RSP_SYS) & sys_rsp_ready);

  assign ifu_cmd_ready = free & ifu_pick;
  assign sys_cmd_ready = free & sys_cmd_valid & ~ifu_pick;
  assign accept        = free & any_valid;

  assign sel_addr = ifu_pick ? ifu_cmd_addr : sys_cmd_addr;
  assign sel_read = ifu_pick ? ifu_cmd_read : sys_cmd_read;
  assign rom_addr = any_valid ? sel_addr[AW-1:2] : '0;

  // Illegal accesses still return exactly one response, with zero data.
  assign cmd_err = ~sel_read
                 | (sel_addr[1:0] != 2'b00)
                 | (32'(sel_addr[AW-1:2]) >= 32'(DP));
  assign rdata_d = cmd_err ? '0 : rom_dout;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q         <= IDLE;
      ifu_rsp_valid_q <= 1'b0;
      ifu_rsp_rdata_q <= '0;
      ifu_rsp_err_q   <= 1'b0;
      sys_rsp_valid_q <= 1'b0;
      sys_rsp_rdata_q <= '0;
      sys_rsp_err_q   <= 1'b0;
`ifdef N101_MROM_ARB_RR_EN
      last_grant_q    <= 1'b1;
`endif
    end else if (accept) begin
      if (ifu_pick) begin
        state_q         <= RSP_IFU;
        ifu_rsp_valid_q <= 1'b1;
        ifu_rsp_rdata_q <= rdata_d;
        ifu_rsp_err_q   <= cmd_err;
        sys_rsp_valid_q <= 1'b0;
      end else begin
        state_q         <= RSP_SYS;
        sys_rsp_valid_q <= 1'b1;
        sys_rsp_rdata_q <= rdata_d;
        sys_rsp_err_q   <= cmd_err;
        ifu_rsp_valid_q <= 1'b0;
      end
`ifdef N101_MROM_ARB_RR_EN
      last_grant_q <= ~ifu_pick;
`endif
    end else if (free) begin
      // Response handshake with nothing new to accept; data stays as last returned.
      state_q         <= IDLE;
      ifu_rsp_valid_q <= 1'b0;
      sys_rsp_valid_q <= 1'b0;
    end
  end

  assign ifu_rsp_valid = ifu_rsp_valid_q;
  assign ifu_rsp_rdata = ifu_rsp_rdata_q;
  assign ifu_rsp_err   = ifu_rsp_err_q;
  assign sys_rsp_valid = sys_rsp_valid_q;
  assign sys_rsp_rdata = sys_rsp_rdata_q;
  assign sys_rsp_err   = sys_rsp_err_q;

endmodule
